apb_master_arbiter: RTL and testbench

Shares one APB master port between `NREQ` independent requesters. Each requester hands over a single read or write command through a valid/ready handshake. Commands are granted round-robin, and the block sequences the APB SETUP and ACCESS phases, honouring `pready` wait states and bounding them with a timeout. It sits between on-chip command sources (bench sequencers, DMA, config engines) and the APB slave memory on the shared `dut_if` bus.

---
 rtl/apb_arb_pkg.sv | 15 +
 rtl/apb_master_arbiter_if.sv | 43 ++++
 rtl/rr_arbiter.sv | 32 +++
 rtl/apb_master_arbiter.sv | 148 ++++++++++++++
 tb/tb_apb_master_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and default widths for the APB master arbiter.
package apb_arb_pkg;

  localparam int unsigned DefNreq    = 4;
  localparam int unsigned DefAw      = 32;
  localparam int unsigned DefDw      = 32;
  localparam int unsigned DefTimeout = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SETUP,
    ARB_ACCESS
  } apb_arb_state_e;

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester command/response channels plus the shared APB master port.
interface apb_master_arbiter_if
  import apb_arb_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned AW   = DefAw,
  parameter int unsigned DW   = DefDw
) ();

  // Requester side
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;

  // APB side
  logic [AW-1:0]      paddr;
  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [DW-1:0]      pwdata;
  logic               pready;
  logic [DW-1:0]      prdata;

  // Arbiter view
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, pready, prdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output paddr, psel, penable, pwrite, pwdata
  );

  // Requesters and APB slave view
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, pready, prdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  paddr, psel, penable, pwrite, pwdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts just after last_grant and wraps.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int unsigned IdxW = $clog2(NREQ);

  logic            found;
  logic [IdxW-1:0] cand;

  // First requesting index in rotated priority order wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      cand = IdxW'((int'(last_grant) + 1 + i) % int'(NREQ));
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NREQ requesters.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NREQ    = DefNreq,
  parameter int unsigned AW      = DefAw,
  parameter int unsigned DW      = DefDw,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  apb_master_arbiter_if.master bus
);

  localparam int unsigned IdxW = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  apb_arb_state_e  state_q, state_d;
  logic [IdxW-1:0] last_grant_q, last_grant_d;
  logic [IdxW-1:0] gnt_idx_q, gnt_idx_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic            pwrite_q, pwrite_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;

  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [NREQ-1:0] arb_grant;
  logic [IdxW-1:0] arb_idx;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  // Accept is only offered while idle; grant vector is already one-hot
  always_comb begin
    bus.req_ready = (state_q == ARB_IDLE) ? arb_grant : '0;
  end

  // Next-state logic for the APB phase sequencer and its registers
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_idx_d    = gnt_idx_q;
    wait_cnt_d   = wait_cnt_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pwrite_d     = pwrite_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (|bus.req_valid) begin
          gnt_idx_d    = arb_idx;
          last_grant_d = arb_idx;
          paddr_d      = bus.req_addr[arb_idx*AW +: AW];
          pwdata_d     = bus.req_wdata[arb_idx*DW +: DW];
          pwrite_d     = bus.req_write[arb_idx];
          psel_d       = 1'b1;
          state_d      = ARB_SETUP;
        end
      end
      ARB_SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
        state_d    = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        // A ready slave wins even on the edge the timeout would fire
        if (bus.pready) begin
          rsp_valid_d[gnt_idx_q] = 1'b1;
          rsp_rdata_d            = pwrite_q ? '0 : bus.prdata;
          psel_d                 = 1'b0;
          penable_d              = 1'b0;
          state_d                = ARB_IDLE;
        end else if (wait_cnt_q == CntW'(TIMEOUT - 1)) begin
          rsp_valid_d[gnt_idx_q] = 1'b1;
          rsp_rdata_d            = '0;
          rsp_err_d              = 1'b1;
          psel_d                 = 1'b0;
          penable_d              = 1'b0;
          state_d                = ARB_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and output registers; reset restarts priority at requester 0
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= IdxW'(NREQ - 1);
      gnt_idx_q    <= '0;
      wait_cnt_q   <= '0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pwrite_q     <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_idx_q    <= gnt_idx_d;
      wait_cnt_q   <= wait_cnt_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pwrite_q     <= pwrite_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Drive registered values onto the interface
  always_comb begin
    bus.paddr     = paddr_q;
    bus.pwdata    = pwdata_q;
    bus.pwrite    = pwrite_q;
    bus.psel      = psel_q;
    bus.penable   = penable_q;
    bus.rsp_valid = rsp_valid_q;
    bus.rsp_rdata = rsp_rdata_q;
    bus.rsp_err   = rsp_err_q;
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a simple APB memory slave.
module tb_apb_master_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 16;
  localparam int          MaxLat  = 40;

  logic pclk = 1'b0;
  logic rst_n;

  apb_master_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  apb_master_arbiter #(
    .NREQ    (NREQ),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 pclk = ~pclk;

  // APB memory slave: mem[i]=i, pready held low for wait_n ACCESS cycles
  logic [31:0] mem [256];
  bit          mem_ready;
  int unsigned acc_cnt;
  int unsigned wait_n;

  assign bus.pready = (acc_cnt >= wait_n);
  assign bus.prdata = mem[bus.paddr[7:0]];

  always @(posedge pclk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
      mem_ready <= 1'b1;
    end else if (bus.psel && bus.penable && bus.pready && bus.pwrite) begin
      mem[bus.paddr[7:0]] <= bus.pwdata;
    end
  end

  always @(posedge pclk) begin
    acc_cnt <= (bus.psel && bus.penable && !bus.pready) ? acc_cnt + 1 : 0;
  end

  typedef struct {
    logic [3:0]  valid;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned wait_n;
    int unsigned exp_g;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic [3:0] valid, logic wr, logic [31:0] addr,
                              logic [31:0] wdata, int unsigned wn, int unsigned g,
                              logic [31:0] rd, logic err, int lat);
    vec_t v;
    v.valid = valid; v.wr = wr; v.addr = addr; v.wdata = wdata; v.wait_n = wn;
    v.exp_g = g; v.exp_rdata = rd; v.exp_err = err; v.exp_lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives one command, follows it to its response negedge
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    bit done;
    bit stable;
    bus.req_valid = v.valid;
    bus.req_write = {NREQ{v.wr}};
    bus.req_addr  = {NREQ{v.addr}};
    bus.req_wdata = {NREQ{v.wdata}};
    wait_n        = v.wait_n;
    #1;
    check({tag, " req_ready"}, 64'(bus.req_ready), 64'(4'b0001 << v.exp_g));
    @(posedge pclk);
    lat = 0;
    done = 1'b0;
    stable = 1'b1;
    while (!done && lat < MaxLat) begin
      @(negedge pclk);
      lat++;
      if (bus.rsp_valid != '0) begin
        done = 1'b1;
      end else begin
        if (bus.psel !== 1'b1 || bus.paddr !== v.addr || bus.pwrite !== v.wr) stable = 1'b0;
        if (bus.req_ready !== '0 || bus.rsp_err !== 1'b0) stable = 1'b0;
        if (v.wr && bus.pwdata !== v.wdata) stable = 1'b0;
        if (bus.penable !== (lat > 1)) stable = 1'b0;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
    check({tag, " rsp_valid"}, 64'(bus.rsp_valid), 64'(4'b0001 << v.exp_g));
    check({tag, " rsp_rdata"}, 64'(bus.rsp_rdata), 64'(v.exp_rdata));
    check({tag, " rsp_err"}, 64'(bus.rsp_err), 64'(v.exp_err));
    check({tag, " apb_stable"}, 64'(stable), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    bit quiet;

    // Single read, write/readback, wait states, then 8 fairness transfers
    vq.push_back(mk(4'b0001, 1'b0, 32'd5,  32'd0,         0,    0, 32'd5,         1'b0, 3));
    vq.push_back(mk(4'b0100, 1'b1, 32'd10, 32'hDEADBEEF,  0,    2, 32'd0,         1'b0, 3));
    vq.push_back(mk(4'b0010, 1'b0, 32'd10, 32'd0,         0,    1, 32'hDEADBEEF,  1'b0, 3));
    vq.push_back(mk(4'b1000, 1'b0, 32'd7,  32'd0,         3,    3, 32'd7,         1'b0, 6));
    for (int i = 0; i < 8; i++)
      vq.push_back(mk(4'b1111, 1'b0, 32'd20, 32'd0, 0, i % 4, 32'd20, 1'b0, 3));
    // Ready on the final allowed edge completes normally; stuck slave aborts
    vq.push_back(mk(4'b0010, 1'b0, 32'd30, 32'd0,         15,   1, 32'd30,        1'b0, 18));
    vq.push_back(mk(4'b0100, 1'b0, 32'd40, 32'd0,         1000, 2, 32'd0,         1'b1, 18));
    vq.push_back(mk(4'b1001, 1'b1, 32'd40, 32'h12345678,  0,    3, 32'd0,         1'b0, 3));
    vq.push_back(mk(4'b0001, 1'b0, 32'd40, 32'd0,         0,    0, 32'h12345678,  1'b0, 3));

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    wait_n        = 0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("reset psel",      64'(bus.psel),      64'd0);
    check("reset penable",   64'(bus.penable),   64'd0);
    check("reset pwrite",    64'(bus.pwrite),    64'd0);
    check("reset paddr",     64'(bus.paddr),     64'd0);
    check("reset pwdata",    64'(bus.pwdata),    64'd0);
    check("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("reset rsp_err",   64'(bus.rsp_err),   64'd0);
    check("reset req_ready", 64'(bus.req_ready), 64'd0);
    rst_n = 1'b1;

    foreach (vq[i]) run_vec(vq[i], $sformatf("v%0d", i));
    bus.req_valid = '0;

    // Reset asserted mid-ACCESS: bus must idle at once with no response
    @(negedge pclk);
    bus.req_valid = 4'b0010;
    bus.req_write = '0;
    bus.req_addr  = {NREQ{32'd50}};
    wait_n        = 1000;
    @(posedge pclk);
    #1 bus.req_valid = '0;
    repeat (3) @(negedge pclk);
    check("midrst psel before", 64'(bus.psel), 64'd1);
    check("midrst penable before", 64'(bus.penable), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst psel", 64'(bus.psel), 64'd0);
    check("midrst penable", 64'(bus.penable), 64'd0);
    check("midrst rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(posedge pclk);
    @(negedge pclk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge pclk);
      if (bus.rsp_valid !== '0 || bus.psel !== 1'b0) quiet = 1'b0;
    end
    check("midrst quiet after", 64'(quiet), 64'd1);
    run_vec(mk(4'b1111, 1'b0, 32'd6, 32'd0, 0, 0, 32'd6, 1'b0, 3), "post_reset");
    bus.req_valid = '0;
    @(negedge pclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
